// File: rtl/router_fsm.sv
// Ingress control FSM for the 1x3 router: decodes the header address, steps the
// byte register through its load phases and drives FIFO write enable and busy.
module router_fsm (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [1:0] addr_sel,
    output logic       detect_addr,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        WAIT_TILL_EMPTY    = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        LOAD_PARITY        = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    state_t     state_reg;
    logic [1:0] addr_sel_reg;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       sel_empty;
    logic       sel_soft_reset;

    assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};

    // addr_sel never holds 3, so indexing by it stays in range; 3 maps to 0 defensively
    assign sel_empty      = (addr_sel_reg == 2'd3) ? 1'b0 : fifo_empty[addr_sel_reg];
    assign sel_soft_reset = (addr_sel_reg == 2'd3) ? 1'b0 : soft_reset[addr_sel_reg];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= DECODE_ADDRESS;
            addr_sel_reg <= 2'b00;
        end else if (sel_soft_reset && state_reg != DECODE_ADDRESS) begin
            state_reg <= DECODE_ADDRESS;
        end else begin
            case (state_reg)
                DECODE_ADDRESS: begin
                    if (pkt_valid) begin
                        if (data_in == 2'd3) begin
                            state_reg <= DROP_PACKET;
                        end else begin
                            addr_sel_reg <= data_in;
                            state_reg    <= fifo_empty[data_in] ? LOAD_FIRST_DATA
                                                                : WAIT_TILL_EMPTY;
                        end
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty) state_reg <= LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_reg <= LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       state_reg <= FIFO_FULL_STATE;
                    else if (!pkt_valid) state_reg <= LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) state_reg <= LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_reg <= DECODE_ADDRESS;
                    else if (low_pkt_valid) state_reg <= LOAD_PARITY;
                    else                    state_reg <= LOAD_DATA;
                end
                LOAD_PARITY: state_reg <= CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_reg <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                DROP_PACKET: begin
                    if (!pkt_valid) state_reg <= DECODE_ADDRESS;
                end
                default: state_reg <= DECODE_ADDRESS;
            endcase
        end
    end

    // Moore outputs: decoded from the state register only
    assign addr_sel      = addr_sel_reg;
    assign detect_addr   = (state_reg == DECODE_ADDRESS);
    assign lfd_state     = (state_reg == LOAD_FIRST_DATA);
    assign ld_state      = (state_reg == LOAD_DATA);
    assign full_state    = (state_reg == FIFO_FULL_STATE);
    assign laf_state     = (state_reg == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_reg == LOAD_DATA) || (state_reg == LOAD_AFTER_FULL) ||
                           (state_reg == LOAD_PARITY) || (state_reg == CHECK_PARITY_ERROR);
    assign busy          = !((state_reg == DECODE_ADDRESS) || (state_reg == LOAD_DATA) ||
                             (state_reg == DROP_PACKET));

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks each packet scenario and checks the
// strobe vector and addr_sel one clock at a time against hand-derived values.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic [1:0] addr_sel;
    logic       detect_addr, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, write_enb_reg, busy;

    int total = 0;
    int bad   = 0;

    // {detect, lfd, ld, full, laf, rst_int, write_enb, busy}
    localparam logic [7:0] O_DEC  = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0001;
    localparam logic [7:0] O_LD   = 8'b0010_0010;
    localparam logic [7:0] O_WAIT = 8'b0000_0001;
    localparam logic [7:0] O_FULL = 8'b0001_0001;
    localparam logic [7:0] O_LAF  = 8'b0000_1011;
    localparam logic [7:0] O_LP   = 8'b0000_0011;
    localparam logic [7:0] O_CPE  = 8'b0000_0111;
    localparam logic [7:0] O_DROP = 8'b0000_0000;

    logic [7:0] outs;
    assign outs = {detect_addr, lfd_state, ld_state, full_state, laf_state,
                   rst_int_reg, write_enb_reg, busy};

    router_fsm dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0),
        .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .addr_sel(addr_sel),
        .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Advance one edge with the current inputs, then check outputs and addr_sel
    task automatic step(input string tag, input logic [7:0] exp, input logic [1:0] exp_sel);
        @(posedge clk);
        #1;
        chk(tag, outs, exp);
        chk({tag, ".sel"}, {6'd0, addr_sel}, {6'd0, exp_sel});
        $display("step %-10s outs=%b addr_sel=%0d", tag, outs, addr_sel);
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        step("reset", O_DEC, 2'd0);
        resetn = 1'b1;
        step("idle", O_DEC, 2'd0);

        // Header to port 1 (empty), three payload bytes, parity
        pkt_valid = 1'b1; data_in = 2'd1;
        step("t1.lfd", O_LFD, 2'd1);
        data_in = 2'd2;
        step("t1.ld0", O_LD, 2'd1);
        step("t1.ld1", O_LD, 2'd1);
        step("t1.ld2", O_LD, 2'd1);
        pkt_valid = 1'b0;
        step("t1.lp", O_LP, 2'd1);
        step("t1.cpe", O_CPE, 2'd1);
        step("t1.dec", O_DEC, 2'd1);

        // Header to port 2 while its FIFO is still draining
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        step("t2.wait0", O_WAIT, 2'd2);
        data_in = 2'd1;
        step("t2.wait1", O_WAIT, 2'd2);
        step("t2.wait2", O_WAIT, 2'd2);
        step("t2.wait3", O_WAIT, 2'd2);
        fifo_empty_2 = 1'b1;
        step("t2.lfd", O_LFD, 2'd2);
        step("t2.ld", O_LD, 2'd2);

        // Full for two cycles mid-payload, resume loading
        fifo_full = 1'b1;
        step("t3.full0", O_FULL, 2'd2);
        step("t3.full1", O_FULL, 2'd2);
        fifo_full = 1'b0;
        step("t3.laf", O_LAF, 2'd2);
        step("t3.ld", O_LD, 2'd2);

        // Full arrives with the parity byte; full wins over pkt_valid low
        pkt_valid = 1'b0; fifo_full = 1'b1;
        step("t4.full", O_FULL, 2'd2);
        fifo_full = 1'b0;
        step("t4.laf", O_LAF, 2'd2);
        low_pkt_valid = 1'b1;
        step("t4.lp", O_LP, 2'd2);
        step("t4.cpe", O_CPE, 2'd2);
        fifo_full = 1'b1;
        step("t4.full2", O_FULL, 2'd2);
        fifo_full = 1'b0;
        step("t4.laf2", O_LAF, 2'd2);
        parity_done = 1'b1;
        step("t4.dec", O_DEC, 2'd2);
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        // Reserved address: packet is dropped, addr_sel untouched
        pkt_valid = 1'b1; data_in = 2'd3;
        step("t5.drop0", O_DROP, 2'd2);
        data_in = 2'd0;
        step("t5.drop1", O_DROP, 2'd2);
        data_in = 2'd1;
        step("t5.drop2", O_DROP, 2'd2);
        step("t5.drop3", O_DROP, 2'd2);
        step("t5.drop4", O_DROP, 2'd2);
        pkt_valid = 1'b0;
        step("t5.dec", O_DEC, 2'd2);

        // Soft reset: only the selected port's request counts
        pkt_valid = 1'b1; data_in = 2'd0;
        step("t6.lfd", O_LFD, 2'd0);
        step("t6.ld", O_LD, 2'd0);
        soft_reset_1 = 1'b1;
        step("t6.sr1", O_LD, 2'd0);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step("t6.sr0", O_DEC, 2'd0);
        // Soft reset is not applied in DECODE_ADDRESS, so a new header still decodes
        data_in = 2'd1;
        step("t6.dec_sr", O_LFD, 2'd1);
        soft_reset_0 = 1'b0;
        step("t6.ld2", O_LD, 2'd1);
        resetn = 1'b0;
        step("t6.rst", O_DEC, 2'd0);
        resetn = 1'b1; pkt_valid = 1'b0;
        step("t6.idle", O_DEC, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
